// File: rtl/pq_access_scheduler.sv
//------------------------------------------------------------------------------
// pq_access_scheduler : round-robin access scheduler for a shared priority queue
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pq_access_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 12
) (
    input  logic                          i_CLK,
    input  logic                          i_RSTn,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*2-1:0]          i_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic                          o_rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_rsp_err,
    output logic                          o_busy,
    output logic                          o_pq_wrt,
    output logic                          o_pq_read,
    output logic [DATA_WIDTH-1:0]         o_pq_data,
    input  logic                          i_pq_full,
    input  logic                          i_pq_empty,
    input  logic [DATA_WIDTH-1:0]         i_pq_data
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam logic [1:0] OP_ENQ = 2'b01;
    localparam logic [1:0] OP_DEQ = 2'b10;
    localparam logic [1:0] OP_REP = 2'b11;

    logic [1:0]            r_state;
    logic [IDW-1:0]        r_rr_ptr;
    logic [IDW-1:0]        r_id;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CW-1:0]         r_cnt;
    logic                  r_rsp_valid;
    logic [IDW-1:0]        r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic                  w_found;
    logic [IDW-1:0]        w_winner;
    logic [1:0]            w_sel_op;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_issue;
    logic                  w_err;
    logic                  w_wrt;
    logic                  w_read;

    // Search starts just past the last winner so every requester gets its turn.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_sel_op   = '0;
        w_sel_data = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[idx]) begin
                w_found    = 1'b1;
                w_winner   = idx[IDW-1:0];
                w_sel_op   = i_op[idx*2 +: 2];
                w_sel_data = i_data[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A zero key is the queue's empty sentinel and can never be stored.
    always_comb begin
        w_issue = (r_state == S_ISSUE);
        case (r_op)
            OP_ENQ:  w_err = i_pq_full || (r_data == '0);
            OP_DEQ:  w_err = i_pq_empty;
            OP_REP:  w_err = (r_data == '0);
            default: w_err = 1'b1;
        endcase
        w_wrt  = w_issue && !w_err && r_op[0];
        w_read = w_issue && !w_err && r_op[1];
    end

    assign o_gnt       = w_issue ? (NUM_REQ'(1) << r_id) : '0;
    assign o_pq_wrt    = w_wrt;
    assign o_pq_read   = w_read;
    assign o_pq_data   = (w_wrt || w_read) ? r_data : '0;
    assign o_busy      = (r_state != S_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= IDW'(NUM_REQ - 1);
            r_id     <= '0;
            r_op     <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id     <= w_winner;
                        r_op     <= w_sel_op;
                        r_data   <= w_sel_data;
                        r_rr_ptr <= w_winner;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_err) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= CW'(SETTLE_CYCLES - 1);
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Head is sampled in the strobe cycle, i.e. before the queue reorders.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_issue;
            r_rsp_id    <= w_issue ? r_id : '0;
            r_rsp_err   <= w_issue && w_err;
            r_rsp_data  <= (w_issue && !w_err && r_op[1]) ? i_pq_data : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pq_access_scheduler.sv
//------------------------------------------------------------------------------
// tb_pq_access_scheduler : scoreboard bench with a behavioural queue and model
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pq_access_scheduler;

    localparam int NR    = 4;
    localparam int DW    = 16;
    localparam int SC    = 12;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*2-1:0] op;
    logic [NR*DW-1:0] dat;
    logic [NR-1:0]   gnt;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            pq_wrt;
    logic            pq_read;
    logic [DW-1:0]   pq_wdata;
    logic            pq_full;
    logic            pq_empty;
    logic [DW-1:0]   pq_head;

    always #5 clk = ~clk;

    pq_access_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
        .i_CLK(clk), .i_RSTn(rst_n), .i_req(req), .i_op(op), .i_data(dat),
        .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_busy(busy),
        .o_pq_wrt(pq_wrt), .o_pq_read(pq_read), .o_pq_data(pq_wdata),
        .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_head)
    );

    // Behavioural stand-in for the priority queue: unsorted store, max is head.
    logic [DW-1:0] emem [DEPTH];
    int            ecnt;
    int            hidx;
    bit            force_full;

    always_comb begin
        pq_head = '0;
        hidx    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < ecnt && emem[i] > pq_head) begin
                pq_head = emem[i];
                hidx    = i;
            end
        end
    end

    assign pq_full  = force_full || (ecnt == DEPTH);
    assign pq_empty = (ecnt == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt <= 0;
        end else if (pq_wrt && pq_read) begin
            if (ecnt > 0) begin
                emem[hidx] <= pq_wdata;
            end else begin
                emem[0] <= pq_wdata;
                ecnt    <= 1;
            end
        end else if (pq_wrt) begin
            if (ecnt < DEPTH) begin
                emem[ecnt] <= pq_wdata;
                ecnt       <= ecnt + 1;
            end
        end else if (pq_read && ecnt > 0) begin
            emem[hidx] <= emem[ecnt-1];
            ecnt       <= ecnt - 1;
        end
    end

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        bit            err;
        bit            wrt;
        bit            rd;
        logic [DW-1:0] pqd;
        int            gap;
    } exp_t;

    exp_t          exp_g[$];
    exp_t          exp_r[$];
    int            errors = 0;
    int            checks = 0;
    int            model_rr = NR - 1;
    logic [DW-1:0] model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a grant or response.
    int cyc = 0;
    int last_gnt_cyc = 0;
    bit prev_gnt = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            prev_gnt = 1'b0;
        end else begin
            check("strobe_without_grant", 32'((pq_wrt || pq_read) && gnt == '0), 32'd0);
            if (gnt != '0) begin
                if (exp_g.size() == 0) begin
                    check("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    e = exp_g.pop_front();
                    check("gnt_id", 32'(gnt), 32'(1) << e.id);
                    check("pq_wrt", 32'(pq_wrt), 32'(e.wrt));
                    check("pq_read", 32'(pq_read), 32'(e.rd));
                    check("pq_data", 32'(pq_wdata), 32'(e.pqd));
                    if (e.gap >= 0) check("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'(e.gap));
                end
                last_gnt_cyc = cyc;
            end
            if (rsp_valid) begin
                check("rsp_latency", 32'(prev_gnt), 32'd1);
                if (exp_r.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_r.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            prev_gnt = (gnt != '0);
        end
    end

    // Reference model: a round's grants follow rotation order from the last
    // winner; each op is resolved against a list of stored keys.
    task automatic predict_round(input logic [NR-1:0] mask, input logic [NR*2-1:0] ops,
                                 input logic [NR*DW-1:0] dv, input bit ff);
        int   start;
        int   gap;
        exp_t e;
        start = model_rr;
        gap   = -1;
        for (int k = 1; k <= NR; k++) begin
            int            p;
            logic [1:0]    o;
            logic [DW-1:0] d;
            logic [DW-1:0] mx;
            int            mi;
            p  = (start + k) % NR;
            if (mask[p]) begin
                o  = ops[p*2 +: 2];
                d  = dv[p*DW +: DW];
                mx = '0;
                mi = -1;
                foreach (model_q[i]) if (model_q[i] > mx) begin mx = model_q[i]; mi = i; end
                e.id = p; e.data = '0; e.gap = gap;
                case (o)
                    2'b01: begin
                        e.err = ff || model_q.size() == DEPTH || d == 0;
                        if (!e.err) model_q.push_back(d);
                    end
                    2'b10: begin
                        e.err = (model_q.size() == 0);
                        if (!e.err) begin e.data = mx; model_q.delete(mi); end
                    end
                    2'b11: begin
                        e.err = (d == 0);
                        if (!e.err) begin
                            e.data = mx;
                            if (mi >= 0) model_q[mi] = d; else model_q.push_back(d);
                        end
                    end
                    default: e.err = 1'b1;
                endcase
                e.wrt = !e.err && (o == 2'b01 || o == 2'b11);
                e.rd  = !e.err && (o == 2'b10 || o == 2'b11);
                e.pqd = (e.wrt || e.rd) ? d : '0;
                exp_g.push_back(e);
                exp_r.push_back(e);
                gap      = e.err ? 2 : SC + 2;
                model_rr = p;
            end
        end
    endtask

    task automatic run_round(input logic [NR-1:0] mask, input logic [NR*2-1:0] ops,
                             input logic [NR*DW-1:0] dv, input bit ff);
        bit done;
        predict_round(mask, ops, dv, ff);
        @(negedge clk);
        force_full = ff;
        op  = ops;
        dat = dv;
        req = mask;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (c == 0) check("first_gnt_latency", 32'(gnt != '0), 32'd1);
            req = req & ~gnt;
            if (req == '0 && exp_g.size() == 0 && exp_r.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            check("round_timeout", 32'd0, 32'd1);
            exp_g.delete();
            exp_r.delete();
            req = '0;
        end
        force_full = 1'b0;
    endtask

    function automatic logic [NR*DW-1:0] pack4(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                                input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        logic [NR-1:0]    m;
        logic [NR*2-1:0]  ro;
        logic [NR*DW-1:0] rd;
        bit               rff;
        bit               got;
        rst_n = 1'b0; req = '0; op = '0; dat = '0; force_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_strobes", 32'({pq_wrt, pq_read}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // single enqueue
        run_round(4'b0001, 8'b01, pack4(16'h0050, 0, 0, 0), 1'b0);
        // clear it, then ordered dequeues, then dequeue of an empty queue
        run_round(4'b0001, 8'b10, '0, 1'b0);
        run_round(4'b0010, 8'b01 << 2, pack4(0, 16'h10, 0, 0), 1'b0);
        run_round(4'b0010, 8'b01 << 2, pack4(0, 16'h30, 0, 0), 1'b0);
        run_round(4'b0010, 8'b01 << 2, pack4(0, 16'h20, 0, 0), 1'b0);
        for (int i = 0; i < 4; i++) run_round(4'b0100, 8'b10 << 4, '0, 1'b0);
        // replace on the head
        run_round(4'b1000, 8'b01 << 6, pack4(0, 0, 0, 16'h30), 1'b0);
        run_round(4'b1000, 8'b11 << 6, pack4(0, 0, 0, 16'h40), 1'b0);
        run_round(4'b1000, 8'b10 << 6, '0, 1'b0);
        // rejected ops: zero key, illegal op, forced full
        run_round(4'b0111, {2'b00, 2'b01, 2'b00, 2'b01}, pack4(16'h0, 16'h5, 16'h9, 0), 1'b0);
        run_round(4'b0001, 8'b01, pack4(16'h77, 0, 0, 0), 1'b1);
        // all four requesters together, then requester 0 again
        run_round(4'b1111, 8'b01010101, pack4(16'h1, 16'h2, 16'h3, 16'h4), 1'b0);
        run_round(4'b0001, 8'b01, pack4(16'h5, 0, 0, 0), 1'b0);

        // reset in the middle of a settle window
        predict_round(4'b0001, 8'b01, pack4(16'h99, 0, 0, 0), 1'b0);
        @(negedge clk);
        op = 8'b01; dat = pack4(16'h99, 0, 0, 0); req = 4'b0001;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (gnt != '0) got = 1'b1;
        end
        req = '0;
        check("rst_test_gnt_seen", 32'(got), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_strobes", 32'({pq_wrt, pq_read}), 32'd0);
        check("midrst_pq_data", 32'(pq_wdata), 32'd0);
        model_rr = NR - 1;
        model_q.delete();
        exp_g.delete();
        exp_r.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_round(4'b0011, 8'b0101, pack4(16'h11, 16'h22, 0, 0), 1'b0);

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            m = NR'($urandom_range(1, 15));
            for (int p = 0; p < NR; p++) begin
                int sel;
                sel = $urandom_range(0, 9);
                ro[p*2 +: 2] = (sel == 0) ? 2'b00 : (sel < 5) ? 2'b01 : (sel < 8) ? 2'b10 : 2'b11;
                rd[p*DW +: DW] = ($urandom_range(0, 19) == 0) ? '0 : DW'($urandom_range(1, 16'hFFFF));
            end
            rff = ($urandom_range(0, 9) == 0);
            run_round(m, ro, rd, rff);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
